// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Default timing is 640x480@60 with the 521-line vertical variant.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CNT_W   = 11;

  localparam int unsigned DEF_H_DISP = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_DISP = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 29;

  typedef enum logic [1:0] {
    PhSync,
    PhBack,
    PhDisp,
    PhFront
  } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts sync, back porch, display, front porch and wraps.
// Advances only when advance is high; reports phase and end-of-axis.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned SYNC = 96,
  parameter int unsigned BP   = 48,
  parameter int unsigned DISP = 640,
  parameter int unsigned FP   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [CNT_W-1:0] cnt,
  output phase_e           phase,
  output logic             wrap,
  output logic             in_disp
);

  localparam int unsigned TOT = SYNC + BP + DISP + FP;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOT - 1);
  localparam logic [CNT_W-1:0] BP_START   = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] DISP_START = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] FP_START   = CNT_W'(SYNC + BP + DISP);

  if (TOT > 2 ** CNT_W) begin : g_width_check
    $error("vga_axis_counter: axis total does not fit the counter width");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    phase = PhFront;
    if (cnt < BP_START) begin
      phase = PhSync;
    end else if (cnt < DISP_START) begin
      phase = PhBack;
    end else if (cnt < FP_START) begin
      phase = PhDisp;
    end
  end

  assign wrap    = (cnt == LAST);
  assign in_disp = (phase == PhDisp);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a one-tick pixel pipeline.
// Define VGA_TEST_PATTERN_EN to replace pixel_color with 8 vertical colour bars.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_DISP   = DEF_H_DISP,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_DISP   = DEF_V_DISP,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COLOR_W-1:0] pixel_color,
  output logic               pixel_req,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start,
  output logic               line_start,
  output logic [COLOR_W-1:0] color,
  output logic               hSync,
  output logic               vSync
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] H_OFF = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_OFF = CNT_W'(V_SYNC + V_BP);

  if (CLK_DIV < 1 || H_DISP > 2 ** COORD_W || V_DISP > 2 ** COORD_W) begin : g_param_check
    $error("vga_timing_gen: CLK_DIV must be >= 1 and display sizes must fit COORD_W");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  phase_e           h_phase, v_phase;
  logic             h_wrap, h_in_disp, v_in_disp;
  logic             unused_v_wrap;

  vga_axis_counter #(
    .SYNC(H_SYNC),
    .BP  (H_BP),
    .DISP(H_DISP),
    .FP  (H_FP)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .advance(tick),
    .cnt    (h_cnt),
    .phase  (h_phase),
    .wrap   (h_wrap),
    .in_disp(h_in_disp)
  );

  vga_axis_counter #(
    .SYNC(V_SYNC),
    .BP  (V_BP),
    .DISP(V_DISP),
    .FP  (V_FP)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .advance(tick & h_wrap),
    .cnt    (v_cnt),
    .phase  (v_phase),
    .wrap   (unused_v_wrap),
    .in_disp(v_in_disp)
  );

  logic             disp;
  logic [CNT_W-1:0] h_off, v_off;
  logic             de_q, hs_q, vs_q, ls_q, fs_q;

  assign disp  = h_in_disp & v_in_disp;
  assign h_off = h_cnt - H_OFF;
  assign v_off = v_cnt - V_OFF;

  // Stage 0: sample the counters and issue the pixel request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_req <= 1'b0;
      pixel_x   <= '0;
      pixel_y   <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      pixel_req <= tick & disp;
      if (tick) begin
        de_q <= disp;
        hs_q <= (h_phase == PhSync);
        vs_q <= (v_phase == PhSync);
        ls_q <= (h_cnt == '0);
        fs_q <= (h_cnt == '0) && (v_cnt == '0);
        if (disp) begin
          pixel_x <= h_off[COORD_W-1:0];
          pixel_y <= v_off[COORD_W-1:0];
        end
      end
    end
  end

  logic [COLOR_W-1:0] next_color;

`ifdef VGA_TEST_PATTERN_EN
  logic [COORD_W+2:0] bar_scaled, bar_idx;
  logic               unused_pixel_color;

  assign unused_pixel_color = ^pixel_color;
  assign bar_scaled = {pixel_x, 3'b000};
  assign bar_idx    = bar_scaled / (COORD_W + 3)'(H_DISP);

  // Bar index is 3 bits; repeat it across wider colour buses.
  always_comb begin
    next_color = '0;
    for (int i = 0; i < COLOR_W; i++) begin
      next_color[i] = bar_idx[i % 3];
    end
  end
`else
  assign next_color = pixel_color;
`endif

  // Stage 1: colour and delayed sync/pulses leave together on the next tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      color       <= '0;
      hSync       <= ~SYNC_POL;
      vSync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= tick & ls_q;
      frame_start <= tick & fs_q;
      if (tick) begin
        color <= de_q ? next_color : '0;
        hSync <= hs_q ? SYNC_POL : ~SYNC_POL;
        vSync <= vs_q ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 15x8 raster, CLK_DIV=2.
// Expected values are hand-computed for H 3/2/8/2 and V 2/1/4/1 timing.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pixel_color = 3'b000;
  logic       pixel_req, frame_start, line_start, hSync, vSync;
  logic [9:0] pixel_x, pixel_y;
  logic [2:0] color;

  always #10 clk = ~clk;

  vga_timing_gen #(
    .COLOR_W (3),
    .CLK_DIV (2),
    .H_DISP  (8),
    .H_FP    (2),
    .H_SYNC  (3),
    .H_BP    (2),
    .V_DISP  (4),
    .V_FP    (1),
    .V_SYNC  (2),
    .V_BP    (1),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_color(pixel_color),
    .pixel_req  (pixel_req),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_start(frame_start),
    .line_start (line_start),
    .color      (color),
    .hSync      (hSync),
    .vSync      (vSync)
  );

  // Upstream renderer: answers each request with the low bits of pixel_x.
  initial begin
    forever begin
      @(negedge clk);
`ifdef VGA_TEST_PATTERN_EN
      pixel_color = 3'b111;
`else
      if (pixel_req) pixel_color = pixel_x[2:0];
`endif
    end
  end

  typedef struct {
    int   m;
    logic hs;
    logic vs;
    logic req;
    int   x;
    int   y;
    int   col;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int mm, input logic hs, input logic vs, input logic req,
                     input int x, input int y, input int col, input logic ls, input logic fs);
    vec_t v;
    v.m = mm; v.hs = hs; v.vs = vs; v.req = req;
    v.x = x; v.y = y; v.col = col; v.ls = ls; v.fs = fs;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    m++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " hSync"}, int'(hSync), 1);
    check({tag, " vSync"}, int'(vSync), 1);
    check({tag, " color"}, int'(color), 0);
    check({tag, " pixel_req"}, int'(pixel_req), 0);
    check({tag, " line_start"}, int'(line_start), 0);
    check({tag, " frame_start"}, int'(frame_start), 0);
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      while (m < vecs[i].m) step();
      check($sformatf("%s m%0d hSync", tag, m), int'(hSync), int'(vecs[i].hs));
      check($sformatf("%s m%0d vSync", tag, m), int'(vSync), int'(vecs[i].vs));
      check($sformatf("%s m%0d pixel_req", tag, m), int'(pixel_req), int'(vecs[i].req));
      check($sformatf("%s m%0d color", tag, m), int'(color), vecs[i].col);
      check($sformatf("%s m%0d line_start", tag, m), int'(line_start), int'(vecs[i].ls));
      check($sformatf("%s m%0d frame_start", tag, m), int'(frame_start), int'(vecs[i].fs));
      if (vecs[i].req) begin
        check($sformatf("%s m%0d pixel_x", tag, m), int'(pixel_x), vecs[i].x);
        check($sformatf("%s m%0d pixel_y", tag, m), int'(pixel_y), vecs[i].y);
      end
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return hSync;
      1:       return vSync;
      2:       return line_start;
      default: return frame_start;
    endcase
  endfunction

  // Width in clks of the next low pulse on hSync (sel 0) or vSync (sel 1); -1 on timeout.
  task automatic measure_low(input int sel, output int width);
    int n = 0;
    while (sig(sel) == 1'b0 && n < 2000) begin step(); n++; end
    while (sig(sel) == 1'b1 && n < 2000) begin step(); n++; end
    if (n >= 2000) begin
      width = -1;
    end else begin
      width = 0;
      do begin width++; step(); end while (sig(sel) == 1'b0 && width < 2000);
    end
  endtask

  // Clks between consecutive pulses on line_start (sel 2) or frame_start (sel 3).
  task automatic measure_period(input int sel, output int period);
    int n = 0;
    while (sig(sel) == 1'b0 && n < 2000) begin step(); n++; end
    if (n >= 2000) begin
      period = -1;
    end else begin
      period = 0;
      do begin period++; step(); end while (sig(sel) == 1'b0 && period < 2000);
    end
  endtask

  initial begin
    int w;
    //    m    hs vs req x  y  col ls fs
    add(  0,   1, 1, 0,  0, 0, 0,  0, 0);
    add(  1,   1, 1, 0,  0, 0, 0,  0, 0);
    add(  3,   0, 0, 0,  0, 0, 0,  1, 1);
    add(  4,   0, 0, 0,  0, 0, 0,  0, 0);
    add(  8,   0, 0, 0,  0, 0, 0,  0, 0);
    add(  9,   1, 0, 0,  0, 0, 0,  0, 0);
    add( 61,   1, 0, 0,  0, 0, 0,  0, 0);
    add( 63,   0, 1, 0,  0, 0, 0,  1, 0);
    add( 93,   0, 1, 0,  0, 0, 0,  1, 0);
    add(101,   1, 1, 1,  0, 0, 0,  0, 0);
    add(102,   1, 1, 0,  0, 0, 0,  0, 0);
    add(103,   1, 1, 1,  1, 0, 0,  0, 0);
    add(105,   1, 1, 1,  2, 0, 1,  0, 0);
    add(106,   1, 1, 0,  0, 0, 1,  0, 0);
    add(115,   1, 1, 1,  7, 0, 6,  0, 0);
    add(117,   1, 1, 0,  0, 0, 7,  0, 0);
    add(119,   1, 1, 0,  0, 0, 0,  0, 0);
    add(205,   1, 1, 1,  7, 3, 6,  0, 0);
    add(242,   1, 1, 0,  0, 0, 0,  0, 0);
    add(243,   0, 0, 0,  0, 0, 0,  1, 1);
    add(244,   0, 0, 0,  0, 0, 0,  0, 0);
    add(341,   1, 1, 1,  0, 0, 0,  0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    m = -1;
    run_table("run1");

    // Mid-line reset while a lit pixel is on the pins.
    while (m < 351) step();
    check("pre-reset color", int'(color), 4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    m = -1;
    run_table("run2");

    measure_low(0, w);
    check("hSync low width", w, 6);
    measure_period(2, w);
    check("line_start period", w, 30);
    measure_low(1, w);
    check("vSync low width", w, 60);
    measure_period(3, w);
    check("frame_start period", w, 240);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
